// File: rtl/uart_loopback_top.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loopback_top
//  Description : UART transmitter with internal loopback into a UART receiver.
//                Frame is start(0), D0..D7 LSB first, optional even parity,
//                stop(1). The receiver listens only to the transmitter's
//                TXD output through a 2-FF synchronizer.
//                Define UART_PARITY_EN for an 11-bit frame with even parity;
//                leave it undefined for a 10-bit frame (Parity_error tied 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loopback_top #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       transmit,
  input  logic [7:0] TX_Data,
  output logic       TXD,
  output logic       busy,
  output logic [7:0] RX_Data,
  output logic       Valid_rx,
  output logic       Parity_error,
  output logic       Stop_error
);

  // Clocks per bit and the counter terminal values derived from it.
  localparam int c_DIV   = CLK_FREQ / BAUD_RATE;
  localparam int c_CNT_W = (c_DIV > 2) ? $clog2(c_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_BIT_END  = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'((c_DIV / 2) - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  uart_state_t          r_tx_state;
  uart_state_t          w_tx_state;
  logic [c_CNT_W-1:0]   r_tx_cnt;
  logic [c_CNT_W-1:0]   w_tx_cnt;
  logic [2:0]           r_tx_idx;
  logic [2:0]           w_tx_idx;
  logic [7:0]           r_tx_data;
  logic [7:0]           w_tx_data;
  logic                 r_tx_txd;
  logic                 w_tx_txd;
  logic                 r_tx_busy;
  logic                 w_tx_busy;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == c_BIT_END);

  // TX next-state logic; the line level is decoded from the state being
  // entered so TXD and busy come straight out of flops.
  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_cnt   = r_tx_cnt;
    w_tx_idx   = r_tx_idx;
    w_tx_data  = r_tx_data;
    case (r_tx_state)
      ST_IDLE: begin
        if (transmit) begin
          w_tx_state = ST_START;
          w_tx_cnt   = '0;
          w_tx_idx   = 3'd0;
          w_tx_data  = TX_Data;
        end
      end
      ST_START: begin
        if (w_tx_bit_end) begin
          w_tx_state = ST_DATA;
          w_tx_cnt   = '0;
          w_tx_idx   = 3'd0;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt = '0;
          if (r_tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_tx_state = ST_PARITY;
`else
            w_tx_state = ST_STOP;
`endif
          end else begin
            w_tx_idx = r_tx_idx + 3'd1;
          end
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      ST_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_state = ST_STOP;
          w_tx_cnt   = '0;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_state = ST_IDLE;
          w_tx_cnt   = '0;
        end else begin
          w_tx_cnt = r_tx_cnt + 1'b1;
        end
      end
      default: begin
        w_tx_state = ST_IDLE;
        w_tx_cnt   = '0;
      end
    endcase

    w_tx_txd  = 1'b1;
    w_tx_busy = 1'b1;
    case (w_tx_state)
      ST_IDLE:   w_tx_busy = 1'b0;
      ST_START:  w_tx_txd  = 1'b0;
      ST_DATA:   w_tx_txd  = w_tx_data[w_tx_idx];
      ST_PARITY: w_tx_txd  = ^w_tx_data;
      default:   w_tx_txd  = 1'b1;
    endcase
  end

  // TX state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
      r_tx_data  <= 8'h00;
      r_tx_txd   <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_idx   <= w_tx_idx;
      r_tx_data  <= w_tx_data;
      r_tx_txd   <= w_tx_txd;
      r_tx_busy  <= w_tx_busy;
    end
  end

  assign TXD  = r_tx_txd;
  assign busy = r_tx_busy;

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic r_line_d;
  logic w_fall;

  // Two-stage synchronizer plus one delayed copy for falling-edge detection;
  // all reset to the idle-high line level so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync1  <= r_tx_txd;
      r_sync2  <= r_sync1;
      r_line_d <= r_sync2;
    end
  end

  assign w_fall = r_line_d & ~r_sync2;

  uart_state_t          r_rx_state;
  uart_state_t          w_rx_state;
  logic [c_CNT_W-1:0]   r_rx_cnt;
  logic [c_CNT_W-1:0]   w_rx_cnt;
  logic [2:0]           r_rx_idx;
  logic [2:0]           w_rx_idx;
  logic [7:0]           r_rx_shift;
  logic [7:0]           w_rx_shift;
  logic [7:0]           r_rx_data;
  logic [7:0]           w_rx_data;
  logic                 r_rx_valid;
  logic                 w_rx_valid;
  logic                 r_rx_serr;
  logic                 w_rx_serr;
  logic                 w_rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 r_rx_par;
  logic                 w_rx_par;
  logic                 r_rx_perr;
  logic                 w_rx_perr;
`endif

  assign w_rx_bit_end = (r_rx_cnt == c_BIT_END);

  // RX next-state logic: half-bit start qualification, then one sample per
  // bit period so every sample lands near mid-bit.
  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_cnt   = r_rx_cnt;
    w_rx_idx   = r_rx_idx;
    w_rx_shift = r_rx_shift;
    w_rx_data  = r_rx_data;
    w_rx_valid = 1'b0;
    w_rx_serr  = r_rx_serr;
`ifdef UART_PARITY_EN
    w_rx_par   = r_rx_par;
    w_rx_perr  = r_rx_perr;
`endif
    case (r_rx_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_rx_state = ST_START;
          w_rx_cnt   = '0;
        end
      end
      ST_START: begin
        if (r_rx_cnt == c_HALF_END) begin
          w_rx_cnt = '0;
          w_rx_idx = 3'd0;
          // A line that is high again at mid-start was only a glitch.
          w_rx_state = r_sync2 ? ST_IDLE : ST_DATA;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_cnt   = '0;
          w_rx_shift = {r_sync2, r_rx_shift[7:1]};
          if (r_rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            w_rx_state = ST_PARITY;
`else
            w_rx_state = ST_STOP;
`endif
          end else begin
            w_rx_idx = r_rx_idx + 3'd1;
          end
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (w_rx_bit_end) begin
          w_rx_cnt   = '0;
          w_rx_par   = r_sync2;
          w_rx_state = ST_STOP;
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_cnt   = '0;
          w_rx_state = ST_IDLE;
          // The byte is delivered even when the frame carries an error.
          w_rx_data  = r_rx_shift;
          w_rx_valid = 1'b1;
          w_rx_serr  = ~r_sync2;
`ifdef UART_PARITY_EN
          w_rx_perr  = r_rx_par ^ (^r_rx_shift);
`endif
        end else begin
          w_rx_cnt = r_rx_cnt + 1'b1;
        end
      end
      default: begin
        w_rx_state = ST_IDLE;
        w_rx_cnt   = '0;
      end
    endcase
  end

  // RX state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= ST_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_serr  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
      r_rx_perr  <= 1'b0;
`endif
    end else begin
      r_rx_state <= w_rx_state;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_idx   <= w_rx_idx;
      r_rx_shift <= w_rx_shift;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_rx_serr  <= w_rx_serr;
`ifdef UART_PARITY_EN
      r_rx_par   <= w_rx_par;
      r_rx_perr  <= w_rx_perr;
`endif
    end
  end

  assign RX_Data    = r_rx_data;
  assign Valid_rx   = r_rx_valid;
  assign Stop_error = r_rx_serr;
`ifdef UART_PARITY_EN
  assign Parity_error = r_rx_perr;
`else
  assign Parity_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_loopback_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loopback_top
//  Description : Self-checking bench for uart_loopback_top with a short bit
//                period; received bytes are checked against a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loopback_top;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD_RATE = 10;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = DIV / 2;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       transmit = 1'b0;
  logic [7:0] TX_Data = 8'h00;
  logic       TXD;
  logic       busy;
  logic [7:0] RX_Data;
  logic       Valid_rx;
  logic       Parity_error;
  logic       Stop_error;

  int total = 0;
  int bad = 0;
  int n_valid = 0;
  int n_sent = 0;
  logic [7:0] sb_q[$];
  logic [7:0] sb_exp;
  logic       prev_valid = 1'b0;

  always #5 clk = ~clk;

  uart_loopback_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .transmit    (transmit),
    .TX_Data     (TX_Data),
    .TXD         (TXD),
    .busy        (busy),
    .RX_Data     (RX_Data),
    .Valid_rx    (Valid_rx),
    .Parity_error(Parity_error),
    .Stop_error  (Stop_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected line levels of one frame, bit 0 first.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Scoreboard: every Valid_rx pops one expected byte.
  always @(negedge clk) begin
    if (!reset && Valid_rx) begin
      n_valid++;
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected_valid observed_q=%0d expected_q=1", sb_q.size());
      end
      total++;
      assert (prev_valid === 1'b0) else begin
        bad++;
        $error("FAIL valid_one_cycle observed=%b expected=0", prev_valid);
      end
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        total++;
        assert (RX_Data === sb_exp) else begin
          bad++;
          $error("FAIL sb_rx_data observed=0x%0h expected=0x%0h", RX_Data, sb_exp);
        end
        total++;
        assert (Parity_error === 1'b0) else begin
          bad++;
          $error("FAIL sb_parity_error observed=%b expected=0", Parity_error);
        end
        total++;
        assert (Stop_error === 1'b0) else begin
          bad++;
          $error("FAIL sb_stop_error observed=%b expected=0", Stop_error);
        end
      end
    end
    prev_valid <= Valid_rx;
  end

  task automatic start_frame(input logic [7:0] b);
    @(negedge clk);
    TX_Data  = b;
    transmit = 1'b1;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    sb_q.push_back(b);
    n_sent++;
  endtask

  task automatic wait_busy_fall(input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_fall_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Send one byte and check every line bit at mid-bit plus exact busy length.
  task automatic send_checked(input logic [7:0] b);
    logic [10:0] fr;
    fr = frame_of(b);
    start_frame(b);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_txd", {31'd0, TXD}, 32'd0);
    for (int k = 0; k < FB; k++) begin
      repeat (HALF) @(posedge clk);
      #1;
      chk($sformatf("txd_bit%0d_of_%02h", k, b), {31'd0, TXD}, {31'd0, fr[k]});
      repeat (DIV - HALF - 1) @(posedge clk);
      #1;
      chk("busy_hold", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    chk("busy_exact_fall", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk($sformatf("rx_data_%02h", b), {24'd0, RX_Data}, {24'd0, b});
    chk("parity_error", {31'd0, Parity_error}, 32'd0);
    chk("stop_error", {31'd0, Stop_error}, 32'd0);
    chk("sb_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    int nv;
    logic [7:0] b;

    // Reset held for 2 clocks.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, TXD}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {24'd0, RX_Data}, 32'd0);
    chk("rst_valid", {31'd0, Valid_rx}, 32'd0);
    chk("rst_perr", {31'd0, Parity_error}, 32'd0);
    chk("rst_serr", {31'd0, Stop_error}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_txd", {31'd0, TXD}, 32'd1);

    // Single byte and edge data patterns.
    send_checked(8'hA5);
    send_checked(8'h00);
    send_checked(8'hFF);

    // Transmit requests during a frame are dropped.
    start_frame(8'h81);
    repeat (3 * DIV) @(posedge clk);
    @(negedge clk);
    TX_Data  = 8'h3C;
    transmit = 1'b1;
    repeat (4) @(negedge clk);
    transmit = 1'b0;
    TX_Data  = 8'h00;
    wait_busy_fall(FB * DIV + 10);
    repeat (2) @(posedge clk);
    #1;
    chk("ignore_rx_data", {24'd0, RX_Data}, 32'h81);
    repeat (2 * DIV) @(posedge clk);
    #1;
    chk("ignore_not_queued", {31'd0, busy}, 32'd0);
    chk("ignore_sb_drained", sb_q.size(), 32'd0);

    // Reset in the middle of the data bits aborts the frame.
    start_frame(8'hC3);
    repeat (3 * DIV) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_txd", {31'd0, TXD}, 32'd1);
    void'(sb_q.pop_back());
    n_sent--;
    nv = n_valid;
    @(negedge clk);
    reset = 1'b0;
    repeat (FB * DIV + 10) @(posedge clk);
    #1;
    chk("midrst_no_valid", n_valid, nv);
    chk("midrst_rx_cleared", {24'd0, RX_Data}, 32'd0);
    send_checked(8'h5A);

    // Random regression.
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom_range(0, 255));
      start_frame(b);
      wait_busy_fall(FB * DIV + 10);
      repeat (2) @(posedge clk);
      #1;
      chk("regr_rx_data", {24'd0, RX_Data}, {24'd0, b});
    end

    repeat (4) @(posedge clk);
    #1;
    chk("valid_count", n_valid, n_sent);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
